prim_arb_burst_lock: RTL and testbench

- Round-robin burst scheduler that shares one downstream resource (a bus or shared port) among N requesters.
- Once a requester wins, its grant is locked for a full multi-beat burst, counted by a valid/ready handshake.
- Sits in front of the shared resource, so the duplicated arbiter tree does not have to handle burst atomicity.
- A stall watchdog aborts hung bursts. An optional redundant beat counter raises a sticky fault on mismatch.

---
 rtl/prim_arb_burst_lock.sv | 158 +++++++++++++++
 tb/tb_prim_arb_burst_lock.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_arb_burst_lock.sv
// +--------------------------------------------------------------------------+
// | prim_arb_burst_lock                                                      |
// | Round-robin arbiter that locks the grant for a whole valid/ready burst,  |
// | with a stall watchdog. Define PRIM_ARB_BURST_LOCK_DUP_EN for a redundant |
// | inverted beat counter that raises a sticky err_o on mismatch.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module prim_arb_burst_lock #(
   parameter int N         = 4,
   parameter int LEN_W     = 4,
   parameter int TIMEOUT_W = 8,
   localparam int IDX_W    = $clog2(N)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N-1:0]     req_i,
   input  logic [LEN_W-1:0] len_i [N],
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             last_o,
   output logic             busy_o,
   output logic             timeout_o,
   output logic             err_o
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_BURST = 2'd1;
   localparam logic [1:0] c_GAP   = 2'd2;
   // Abort fires on the stall that would bring the watchdog to all-ones.
   localparam logic [TIMEOUT_W-1:0] c_WDOG_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

   logic [1:0]           r_state;
   logic [1:0]           w_state_nxt;
   logic [IDX_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     r_idx;
   logic [LEN_W-1:0]     r_cnt;
   logic [TIMEOUT_W-1:0] r_wdog;
   logic                 r_timeout;

   logic [IDX_W-1:0]     w_winner;
   logic [IDX_W:0]       w_sum;
   logic [IDX_W-1:0]     w_pos;
   logic [IDX_W-1:0]     w_idx_inc;
   logic                 w_any;
   logic                 w_load;
   logic                 w_beat;
   logic                 w_dec;
   logic                 w_done;
   logic                 w_expire;

   assign w_any     = |req_i;
   assign w_load    = (r_state == c_IDLE) & w_any;
   assign w_beat    = (r_state == c_BURST) & ready_i;
   assign w_dec     = w_beat & (r_cnt != '0);
   assign w_done    = w_beat & (r_cnt == '0);
   assign w_expire  = (r_state == c_BURST) & ~ready_i & (r_wdog == c_WDOG_LAST);
   assign w_idx_inc = (r_idx == IDX_W'(N-1)) ? '0 : r_idx + IDX_W'(1);

   // Descending scan so the lowest rotated offset from r_ptr wins.
   always_comb begin
      w_winner = '0;
      w_sum    = '0;
      w_pos    = '0;
      for (int i = N-1; i >= 0; i--) begin
         w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
         w_pos = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N))
                                         : w_sum[IDX_W-1:0];
         if (req_i[w_pos]) w_winner = w_pos;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= c_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_any) w_state_nxt = c_BURST;
         c_BURST: if (w_done || w_expire) w_state_nxt = c_GAP;
         c_GAP:   w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      gnt_o     = '0;
      idx_o     = '0;
      valid_o   = 1'b0;
      last_o    = 1'b0;
      busy_o    = 1'b0;
      timeout_o = r_timeout;
      case (r_state)
         c_BURST: begin
            gnt_o[r_idx] = 1'b1;
            idx_o        = r_idx;
            valid_o      = 1'b1;
            last_o       = (r_cnt == '0);
            busy_o       = 1'b1;
         end
         c_GAP:   busy_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr     <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (w_load) begin
            r_idx  <= w_winner;
            r_cnt  <= len_i[w_winner];
            r_wdog <= '0;
         end else if (w_dec) begin
            r_cnt  <= r_cnt - LEN_W'(1);
            r_wdog <= '0;
         end else if (w_done || w_expire) begin
            r_ptr  <= w_idx_inc;
         end else if (r_state == c_BURST) begin
            r_wdog <= r_wdog + TIMEOUT_W'(1);
         end
      end
   end

`ifdef PRIM_ARB_BURST_LOCK_DUP_EN
   logic [LEN_W-1:0] r_cnt_n;
   logic             r_err;

   // Inverse copy counts up as r_cnt counts down, so the XOR stays all-ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt_n <= '1;
         r_err   <= 1'b0;
      end else begin
         if (w_load)     r_cnt_n <= ~len_i[w_winner];
         else if (w_dec) r_cnt_n <= r_cnt_n + LEN_W'(1);
         if (((r_cnt ^ r_cnt_n) != '1) || (r_state > c_GAP)) r_err <= 1'b1;
      end
   end

   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prim_arb_burst_lock.sv
// Bench for prim_arb_burst_lock: directed literal checks plus randomized
// traffic compared every cycle against a transaction-level reference model.
`default_nettype none

module tb_prim_arb_burst_lock;

   localparam int N  = 4;
   localparam int LW = 4;
   localparam int TW = 3;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [N-1:0]  req_i;
   logic [LW-1:0] len_i [N];
   logic          ready_i;
   logic [N-1:0]  gnt_o;
   logic [1:0]    idx_o;
   logic          valid_o, last_o, busy_o, timeout_o, err_o;

   int tests  = 0;
   int failed = 0;
   bit model_en = 1'b1;

   // Reference model: who owns the resource and how many beats remain.
   int m_owner  = -1;
   int m_left   = 0;
   int m_stalls = 0;
   int m_ptr    = 0;
   bit m_gap    = 1'b0;
   bit m_tmo    = 1'b0;

   prim_arb_burst_lock #(.N(N), .LEN_W(LW), .TIMEOUT_W(TW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .len_i(len_i),
      .gnt_o(gnt_o), .idx_o(idx_o), .valid_o(valid_o), .ready_i(ready_i),
      .last_o(last_o), .busy_o(busy_o), .timeout_o(timeout_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int dut_outs();
      return int'({gnt_o, idx_o, valid_o, last_o, busy_o, timeout_o, err_o});
   endfunction

   function automatic int model_outs();
      logic [N-1:0] g;
      logic [1:0]   ix;
      logic         v, l, b;
      g  = '0;
      ix = '0;
      v  = (m_owner >= 0);
      if (v) begin
         g[m_owner] = 1'b1;
         ix = 2'(m_owner);
      end
      l = v && (m_left == 1);
      b = v || m_gap;
      return int'({g, ix, v, l, b, m_tmo, 1'b0});
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!valid_o && n < 40) begin cyc(); n++; end
      chk(nm, int'(valid_o), 1);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy_o && n < 40) begin cyc(); n++; end
      chk(nm, int'(busy_o), 0);
   endtask

   task automatic model_end_burst();
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_gap   = 1'b1;
   endtask

   task automatic model_step();
      bit found;
      if (rst_i) begin
         m_owner = -1; m_left = 0; m_stalls = 0; m_ptr = 0;
         m_gap = 1'b0; m_tmo = 1'b0;
      end else begin
         m_tmo = 1'b0;
         if (m_owner >= 0) begin
            if (ready_i) begin
               if (m_left == 1) model_end_burst();
               else begin m_left--; m_stalls = 0; end
            end else begin
               m_stalls++;
               if (m_stalls == (1 << TW) - 1) begin
                  m_tmo = 1'b1;
                  model_end_burst();
               end
            end
         end else if (m_gap) begin
            m_gap = 1'b0;
         end else if (req_i != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               if (!found && req_i[(m_ptr + k) % N]) begin
                  found   = 1'b1;
                  m_owner = (m_ptr + k) % N;
               end
            end
            m_left   = int'(len_i[m_owner]) + 1;
            m_stalls = 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk_i or posedge rst_i);
      model_step();
   end

   initial forever begin
      @(negedge clk_i);
      if (model_en) chk("model", dut_outs(), model_outs());
   end

   initial begin
      rst_i   = 1'b1;
      req_i   = 4'b1111;
      ready_i = 1'b1;
      for (int i = 0; i < N; i++) len_i[i] = '0;

      // Reset and round-robin with single-beat bursts
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_hold_outs", dut_outs(), 0);
      rst_i = 1'b0;
      chk("release_outs", dut_outs(), 0);
      cyc();
      chk("first_gnt", int'(gnt_o), 4'b0001);
      for (int k = 0; k < 5; k++) begin
         wait_valid("rr_wait");
         chk("rr_idx", int'(idx_o), k % N);
         chk("rr_last", int'(last_o), 1);
         cyc();
      end
      req_i = '0;
      wait_idle("rr_idle");

      // Single four-beat burst
      req_i    = 4'b0100;
      len_i[2] = 4'd3;
      wait_valid("single_wait");
      req_i = '0;
      for (int b = 0; b < 4; b++) begin
         chk("single_gnt", int'(gnt_o), 4'b0100);
         chk("single_last", int'(last_o), (b == 3) ? 1 : 0);
         cyc();
      end
      chk("single_gap", int'({gnt_o, valid_o, busy_o}), 6'b000001);
      cyc();
      chk("single_idle", int'(busy_o), 0);

      // Watchdog expiry after seven stalled cycles, then next requester
      for (int i = 0; i < N; i++) len_i[i] = 4'd1;
      ready_i = 1'b0;
      req_i   = 4'b0011;
      wait_valid("tmo_wait");
      chk("tmo_idx", int'(idx_o), 0);
      for (int s = 0; s < 7; s++) begin
         chk("tmo_stall", int'({valid_o, timeout_o}), 2'b10);
         cyc();
      end
      chk("tmo_pulse", int'({timeout_o, valid_o, busy_o}), 3'b101);
      cyc();
      chk("tmo_clear", int'(timeout_o), 0);
      cyc();
      chk("tmo_next_idx", int'({valid_o, idx_o}), 3'b101);
      req_i = '0;
      repeat (6) cyc();
      chk("late_ready_stall", int'({valid_o, timeout_o}), 2'b10);
      ready_i = 1'b1;
      cyc();
      chk("late_ready_beat", int'({valid_o, last_o, timeout_o}), 3'b110);
      cyc();
      chk("late_ready_gap", int'({timeout_o, busy_o}), 2'b01);
      wait_idle("late_ready_idle");

      // Reset in the middle of a burst returns the pointer to zero
      ready_i  = 1'b0;
      req_i    = 4'b0100;
      len_i[2] = 4'd5;
      wait_valid("rst_mid_wait");
      cyc();
      cyc();
      rst_i = 1'b1;
      #1;
      chk("rst_mid_outs", dut_outs(), 0);
      cyc();
      rst_i = 1'b0;
      for (int i = 0; i < N; i++) len_i[i] = '0;
      req_i   = 4'b1111;
      ready_i = 1'b1;
      wait_valid("rst_mid_regrant");
      chk("rst_mid_ptr", int'(idx_o), 0);
      req_i = '0;
      wait_idle("rst_mid_idle");

      // Committed burst ignores request drop and length change
      req_i    = 4'b1000;
      len_i[3] = 4'd2;
      wait_valid("commit_wait");
      chk("commit_idx", int'(idx_o), 3);
      req_i    = '0;
      len_i[3] = 4'd0;
      for (int b = 0; b < 3; b++) begin
         chk("commit_beat", int'({valid_o, last_o}), (b == 2) ? 3 : 2);
         cyc();
      end
      chk("commit_gap", int'({valid_o, busy_o}), 2'b01);

      // Randomized traffic with phases of light and heavy backpressure
      for (int c = 0; c < 3000; c++) begin
         req_i = 4'($urandom);
         for (int i = 0; i < N; i++) len_i[i] = 4'($urandom);
         case ((c / 64) % 3)
            0:       ready_i = ($urandom_range(0, 9) != 0);
            1:       ready_i = ($urandom_range(0, 1) != 0);
            default: ready_i = ($urandom_range(0, 9) == 0);
         endcase
         cyc();
      end

`ifdef PRIM_ARB_BURST_LOCK_DUP_EN
      begin
         logic [LW-1:0] t;
         model_en = 1'b0;
         req_i    = 4'b0100;
         len_i[2] = 4'd7;
         ready_i  = 1'b0;
         wait_idle("fault_idle");
         wait_valid("fault_wait");
         chk("fault_err_before", int'(err_o), 0);
         t = dut.r_cnt ^ 4'b0001;
         force dut.r_cnt = t;
         cyc();
         release dut.r_cnt;
         chk("fault_err_set", int'(err_o), 1);
         repeat (3) cyc();
         chk("fault_err_sticky", int'(err_o), 1);
         rst_i = 1'b1;
         #1;
         chk("fault_err_reset", int'(err_o), 0);
         cyc();
         rst_i = 1'b0;
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
